// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle control sequencer for the 4-bit computer
// Optional build macro CU_SINGLE_STEP_EN adds a Step input and a PAUSE state
// between instructions.
module cpu_control_unit #(
    parameter int N   = 4,
    parameter int PCW = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           run_i,
`ifdef CU_SINGLE_STEP_EN
    input  logic           step_i,
`endif
    input  logic [10:0]    instr_i,
    input  logic           zero_i,
    output logic [PCW-1:0] pc_o,
    output logic [1:0]     alu_op_o,
    output logic [1:0]     rd_addr_o,
    output logic [1:0]     rs_addr_o,
    output logic [N-1:0]   imm_o,
    output logic           wb_sel_o,
    output logic           reg_write_o,
    output logic           zflag_o,
    output logic           halted_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;
`ifdef CU_SINGLE_STEP_EN
    localparam logic [2:0] S_PAUSE     = 3'd6;
`endif

    logic [2:0]     state_q, state_d;
    logic [10:0]    ir_q, ir_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic [1:0]     rd_q, rd_d;
    logic [1:0]     rs_q, rs_d;
    logic [N-1:0]   imm_q, imm_d;
    logic           wb_sel_q, wb_sel_d;
    logic           reg_write_q, reg_write_d;
    logic           zflag_q, zflag_d;
    logic           halted_q, halted_d;

    logic [2:0]     opc;
    logic           is_alu, is_ldi, is_brz, is_halt;
    logic [N-1:0]   imm_ext;
    logic [PCW-1:0] br_target;

    assign opc     = ir_q[10:8];
    assign is_alu  = ~opc[2];
    assign is_ldi  = (opc == 3'b100);
    assign is_brz  = (opc == 3'b101);
    assign is_halt = (opc == 3'b111);

    // Immediate field zero-extended (or truncated) to the data and PC widths
    always_comb begin
        imm_ext   = '0;
        br_target = '0;
        for (int b = 0; b < N; b++)
            imm_ext[b] = (b < 4) ? ir_q[b % 4] : 1'b0;
        for (int b = 0; b < PCW; b++)
            br_target[b] = (b < 4) ? ir_q[b % 4] : 1'b0;
    end

    // Sequencer next-state: one instruction per FETCH/DECODE/EXECUTE/WRITEBACK pass
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        imm_d       = imm_q;
        wb_sel_d    = wb_sel_q;
        reg_write_d = 1'b0;
        zflag_d     = zflag_q;
        halted_d    = halted_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr_i;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                rd_d     = ir_q[7:6];
                rs_d     = ir_q[5:4];
                imm_d    = imm_ext;
                wb_sel_d = is_ldi;
                if (is_alu) alu_op_d = opc[1:0];
                state_d  = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Strobe is registered, so it is raised here to be high during WRITEBACK
                reg_write_d = is_alu | is_ldi;
                state_d     = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (is_alu) zflag_d = zero_i;
                pc_d = (is_brz && zflag_q) ? br_target : pc_q + PCW'(1);
                if (is_halt) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                end else if (run_i) begin
`ifdef CU_SINGLE_STEP_EN
                    state_d = S_PAUSE;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                halted_d = 1'b1;
            end
`ifdef CU_SINGLE_STEP_EN
            S_PAUSE: begin
                if (!run_i)      state_d = S_IDLE;
                else if (step_i) state_d = S_FETCH;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            pc_q        <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            imm_q       <= '0;
            wb_sel_q    <= 1'b0;
            reg_write_q <= 1'b0;
            zflag_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            pc_q        <= pc_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            imm_q       <= imm_d;
            wb_sel_q    <= wb_sel_d;
            reg_write_q <= reg_write_d;
            zflag_q     <= zflag_d;
            halted_q    <= halted_d;
        end
    end

    assign pc_o        = pc_q;
    assign alu_op_o    = alu_op_q;
    assign rd_addr_o   = rd_q;
    assign rs_addr_o   = rs_q;
    assign imm_o       = imm_q;
    assign wb_sel_o    = wb_sel_q;
    assign reg_write_o = reg_write_q;
    assign zflag_o     = zflag_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed bench for cpu_control_unit
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic        zero = 1'b0;
    logic [10:0] instr;
    logic [3:0]  pc;
    logic [1:0]  alu_op, rd, rs;
    logic [3:0]  imm;
    logic        wb_sel, reg_write, zflag, halted;

    logic [10:0] imem [0:15];
    int total = 0;
    int bad = 0;

    localparam logic [10:0] NOP = 11'b110_00_00_0000;

    assign instr = imem[pc];

    always #5 clk = ~clk;

    cpu_control_unit #(.N(4), .PCW(4)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run),
`ifdef CU_SINGLE_STEP_EN
        .step_i(step),
`endif
        .instr_i(instr), .zero_i(zero),
        .pc_o(pc), .alu_op_o(alu_op), .rd_addr_o(rd), .rs_addr_o(rs),
        .imm_o(imm), .wb_sel_o(wb_sel), .reg_write_o(reg_write),
        .zflag_o(zflag), .halted_o(halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_nops();
        for (int k = 0; k < 16; k++) imem[k] = NOP;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; zero = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load_nops();
        rst = 1'b1; run = 1'b1;
        tick();
        total++; if ({pc, alu_op, rd, rs, imm, wb_sel, reg_write, zflag, halted} !== 19'd0) begin
            bad++; $display("FAIL reset_outputs: got %0h want 0", {pc, alu_op, rd, rs, imm, wb_sel, reg_write, zflag, halted}); end
        tick();
        total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc_held: got %0d want 0", pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
        rst = 1'b0; run = 1'b0;
    endtask

    task automatic test_program();
        do_reset(); load_nops();
        imem[0] = 11'b100_01_00_0101;
        imem[1] = 11'b100_10_00_0011;
        imem[2] = 11'b000_01_10_0000;
        imem[3] = 11'b111_00_00_0000;
        run = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            total++; if (reg_write !== (i == 4 || i == 8 || i == 12)) begin
                bad++; $display("FAIL prog_regwrite_c%0d: got %0b want %0b", i, reg_write, (i == 4 || i == 8 || i == 12)); end
            if (i == 4) begin
                total++; if (rd !== 2'd1) begin bad++; $display("FAIL prog_rd1: got %0d want 1", rd); end
                total++; if (wb_sel !== 1'b1) begin bad++; $display("FAIL prog_wbsel1: got %0b want 1", wb_sel); end
                total++; if (imm !== 4'd5) begin bad++; $display("FAIL prog_imm1: got %0d want 5", imm); end
            end
            if (i == 8) begin
                total++; if (rd !== 2'd2) begin bad++; $display("FAIL prog_rd2: got %0d want 2", rd); end
                total++; if (imm !== 4'd3) begin bad++; $display("FAIL prog_imm2: got %0d want 3", imm); end
            end
            if (i == 12) begin
                total++; if (rd !== 2'd1) begin bad++; $display("FAIL prog_rd3: got %0d want 1", rd); end
                total++; if (rs !== 2'd2) begin bad++; $display("FAIL prog_rs3: got %0d want 2", rs); end
                total++; if (alu_op !== 2'd0) begin bad++; $display("FAIL prog_aluop3: got %0d want 0", alu_op); end
                total++; if (wb_sel !== 1'b0) begin bad++; $display("FAIL prog_wbsel3: got %0b want 0", wb_sel); end
            end
            if (i == 15) begin
                total++; if (halted !== 1'b0) begin bad++; $display("FAIL prog_halted_early: got %0b want 0", halted); end
            end
        end
        tick();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL prog_halted: got %0b want 1", halted); end
        total++; if (pc !== 4'd4) begin bad++; $display("FAIL prog_halt_pc: got %0d want 4", pc); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if ({halted, reg_write, pc} !== {1'b1, 1'b0, 4'd4}) begin
                bad++; $display("FAIL halted_stays: got h=%0b rw=%0b pc=%0d want h=1 rw=0 pc=4", halted, reg_write, pc); end
        end
    endtask

    task automatic test_brz(input logic zval);
        do_reset(); load_nops();
        imem[0] = 11'b001_01_01_0000;
        imem[1] = 11'b101_00_00_1001;
        zero = zval; run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 4) begin
                total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL brz_sub_rw: got %0b want 1", reg_write); end
                total++; if (alu_op !== 2'd1) begin bad++; $display("FAIL brz_sub_aluop: got %0d want 1", alu_op); end
            end
            if (i == 5) begin
                total++; if (zflag !== zval) begin bad++; $display("FAIL brz_zflag: got %0b want %0b", zflag, zval); end
                total++; if (pc !== 4'd1) begin bad++; $display("FAIL brz_pc1: got %0d want 1", pc); end
                zero = ~zval;
            end
            if (i == 8) begin
                total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL brz_rw: got %0b want 0", reg_write); end
            end
        end
        total++; if (pc !== (zval ? 4'd9 : 4'd2)) begin bad++; $display("FAIL brz_pc: got %0d want %0d", pc, (zval ? 4'd9 : 4'd2)); end
        total++; if (zflag !== zval) begin bad++; $display("FAIL brz_zflag_kept: got %0b want %0b", zflag, zval); end
    endtask

    task automatic test_wrap();
        int pulses;
        do_reset(); load_nops();
        imem[15] = 11'b011_11_00_0000;
        run = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (reg_write) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL wrap_nop_pulses: got %0d want 0", pulses); end
        total++; if (pc !== 4'd15) begin bad++; $display("FAIL wrap_pc15: got %0d want 15", pc); end
        tick();
        total++; if ({reg_write, alu_op, rd, wb_sel} !== {1'b1, 2'd3, 2'd3, 1'b0}) begin
            bad++; $display("FAIL wrap_not: got rw=%0b op=%0d rd=%0d wb=%0b want rw=1 op=3 rd=3 wb=0", reg_write, alu_op, rd, wb_sel); end
        tick();
        total++; if (pc !== 4'd0) begin bad++; $display("FAIL wrap_pc0: got %0d want 0", pc); end
    endtask

    task automatic test_run_drop();
        do_reset(); load_nops();
        imem[0] = 11'b000_10_11_0000;
        imem[1] = 11'b100_00_00_0111;
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        tick();
        total++; if ({rd, rs} !== {2'd2, 2'd3}) begin bad++; $display("FAIL drop_decode: got rd=%0d rs=%0d want rd=2 rs=3", rd, rs); end
        tick();
        total++; if (reg_write !== 1'b1) begin bad++; $display("FAIL drop_writeback: got %0b want 1", reg_write); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({reg_write, pc} !== {1'b0, 4'd1}) begin
                bad++; $display("FAIL drop_idle: got rw=%0b pc=%0d want rw=0 pc=1", reg_write, pc); end
        end
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (reg_write !== (i == 4)) begin bad++; $display("FAIL resume_rw_c%0d: got %0b want %0b", i, reg_write, (i == 4)); end
        end
        total++; if ({rd, imm, wb_sel} !== {2'd0, 4'd7, 1'b1}) begin
            bad++; $display("FAIL resume_ldi: got rd=%0d imm=%0d wb=%0b want rd=0 imm=7 wb=1", rd, imm, wb_sel); end
    endtask

    task automatic test_reset_mid();
        do_reset(); load_nops();
        imem[0] = 11'b100_11_00_1001;
        run = 1'b1;
        tick(); tick(); tick();
        total++; if ({rd, imm, wb_sel} !== {2'd3, 4'd9, 1'b1}) begin
            bad++; $display("FAIL mid_pre: got rd=%0d imm=%0d wb=%0b want rd=3 imm=9 wb=1", rd, imm, wb_sel); end
        rst = 1'b1;
        #1;
        total++; if ({pc, alu_op, rd, rs, imm, wb_sel, reg_write, zflag, halted} !== 19'd0) begin
            bad++; $display("FAIL mid_async_clear: got %0h want 0", {pc, alu_op, rd, rs, imm, wb_sel, reg_write, zflag, halted}); end
        tick();
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL mid_no_strobe: got %0b want 0", reg_write); end
        rst = 1'b0; run = 1'b0;
        tick(); tick();
        total++; if ({reg_write, pc} !== {1'b0, 4'd0}) begin bad++; $display("FAIL mid_idle: got rw=%0b pc=%0d want 0 0", reg_write, pc); end
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (reg_write !== (i == 4)) begin bad++; $display("FAIL mid_restart_c%0d: got %0b want %0b", i, reg_write, (i == 4)); end
        end
        total++; if (rd !== 2'd3) begin bad++; $display("FAIL mid_restart_rd: got %0d want 3", rd); end
    endtask

`ifdef CU_SINGLE_STEP_EN
    task automatic test_step();
        do_reset(); load_nops();
        imem[0] = 11'b100_01_00_0001;
        imem[1] = 11'b100_10_00_0010;
        imem[2] = 11'b100_11_00_0011;
        run = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 4) begin
                total++; if ({reg_write, rd} !== {1'b1, 2'd1}) begin bad++; $display("FAIL step_first: got rw=%0b rd=%0d want 1 1", reg_write, rd); end
            end
            if (i >= 5) begin
                total++; if ({reg_write, pc} !== {1'b0, 4'd1}) begin bad++; $display("FAIL step_pause_c%0d: got rw=%0b pc=%0d want 0 1", i, reg_write, pc); end
            end
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        total++; if (reg_write !== 1'b0) begin bad++; $display("FAIL step_early: got %0b want 0", reg_write); end
        tick();
        total++; if ({reg_write, rd} !== {1'b1, 2'd2}) begin bad++; $display("FAIL step_second: got rw=%0b rd=%0d want 1 2", reg_write, rd); end
        tick(); tick();
        total++; if ({reg_write, pc} !== {1'b0, 4'd2}) begin bad++; $display("FAIL step_wait: got rw=%0b pc=%0d want 0 2", reg_write, pc); end
        run = 1'b0;
        tick(); tick();
        run = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (reg_write !== (i == 4)) begin bad++; $display("FAIL step_idle_resume_c%0d: got %0b want %0b", i, reg_write, (i == 4)); end
        end
        total++; if (rd !== 2'd3) begin bad++; $display("FAIL step_idle_rd: got %0d want 3", rd); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef CU_SINGLE_STEP_EN
        test_step();
`else
        test_program();
        test_brz(1'b1);
        test_brz(1'b0);
        test_wrap();
        test_run_drop();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
